tdm_demultiplexer: RTL and testbench

//  Receive end of the 4:1 multiplexer link: the multiplexer serializes in0..in3 onto one

---
 rtl/tdm_demultiplexer_pkg.sv | 14 +
 rtl/tdm_demultiplexer_if.sv | 28 ++
 rtl/tdm_demultiplexer_slot_counter.sv | 27 ++
 rtl/tdm_demultiplexer.sv | 134 +++++++++++++
 tb/tb_tdm_demultiplexer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/tdm_demultiplexer_pkg.sv
// Shared definitions for the TDM demultiplexer: FSM states, slot addresses and frame size.
// The slot constants match the addressing used by the 4:1 multiplexer on the far end.
package tdm_pkg;

  typedef enum logic {HUNT, LOCKED} tdm_state_t;

  localparam logic [1:0] SLOT0 = 2'b00;
  localparam logic [1:0] SLOT1 = 2'b01;
  localparam logic [1:0] SLOT2 = 2'b10;
  localparam logic [1:0] SLOT3 = 2'b11;

  localparam int NUM_SLOTS = 4;

endpackage

// File: rtl/tdm_demultiplexer_if.sv
// Bundle of the serial input link and the recovered-channel outputs of the demultiplexer.
// The design uses the slave modport; the driver of the serial link uses the master modport.
interface tdm_demultiplexer_if #(parameter int WIDTH = 1) ();
  import tdm_pkg::*;

  logic                         enable;
  logic                         sync;
  logic [WIDTH-1:0]             din;
  logic [WIDTH-1:0]             out0;
  logic [WIDTH-1:0]             out1;
  logic [WIDTH-1:0]             out2;
  logic [WIDTH-1:0]             out3;
  logic                         frame_valid;
  logic [$clog2(NUM_SLOTS)-1:0] slot_addr;
  logic                         locked;
  logic                         sync_error;

  modport slave (
    input  enable, sync, din,
    output out0, out1, out2, out3, frame_valid, slot_addr, locked, sync_error
  );

  modport master (
    output enable, sync, din,
    input  out0, out1, out2, out3, frame_valid, slot_addr, locked, sync_error
  );

endinterface

// File: rtl/tdm_demultiplexer_slot_counter.sv
// Two-bit wrapping slot counter: a load forces slot 1 (the slot after a sync sample),
// otherwise an increment steps modulo four.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_inc,
  input  logic       i_load1,
  output logic [1:0] o_count
);

  logic [1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= SLOT0;
    end else if (i_load1) begin
      r_count <= SLOT1;
    end else if (i_inc) begin
      r_count <= r_count + 2'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/tdm_demultiplexer.sv
// Receive side of the 4:1 TDM link: aligns to the frame-start strobe, collects slots 0..2
// in a shadow bank and publishes all four channels at once when slot 3 arrives.
module tdm_demultiplexer
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  tdm_demultiplexer_if.slave   bus
);

  tdm_state_t       r_state;
  tdm_state_t       w_nextState;
  logic [1:0]       w_slot;
  logic             w_load1;
  logic             w_inc;
  logic             w_capture;
  logic             w_resync;
  logic             w_commit;

  logic [WIDTH-1:0] r_shadow0;
  logic [WIDTH-1:0] r_shadow1;
  logic [WIDTH-1:0] r_shadow2;
  logic [WIDTH-1:0] r_out0;
  logic [WIDTH-1:0] r_out1;
  logic [WIDTH-1:0] r_out2;
  logic [WIDTH-1:0] r_out3;
  logic             r_frameValid;
  logic             r_syncError;

  tdm_slot_counter u_slotCounter (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_inc),
    .i_load1 (w_load1),
    .o_count (w_slot)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A sync on slot 0 is an ordinary sample; only a sync elsewhere counts as misalignment.
  always_comb begin
    w_nextState = r_state;
    w_load1     = 1'b0;
    w_inc       = 1'b0;
    w_capture   = 1'b0;
    w_resync    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      HUNT: begin
        if (bus.enable && bus.sync) begin
          w_nextState = LOCKED;
          w_load1     = 1'b1;
          w_capture   = 1'b1;
        end
      end
      LOCKED: begin
        if (bus.enable) begin
          if (bus.sync && (w_slot != SLOT0)) begin
            w_resync  = 1'b1;
            w_load1   = 1'b1;
          end else begin
            w_inc = 1'b1;
            if (w_slot == SLOT3) begin
              w_commit = 1'b1;
            end else begin
              w_capture = 1'b1;
            end
          end
        end
      end
      default: begin
        w_nextState = HUNT;
      end
    endcase
  end

  // On re-sync the stale partial frame is wiped so it can never leak into the output bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow0 <= '0;
      r_shadow1 <= '0;
      r_shadow2 <= '0;
    end else if (w_resync) begin
      r_shadow0 <= bus.din;
      r_shadow1 <= '0;
      r_shadow2 <= '0;
    end else if (w_capture) begin
      case (w_slot)
        SLOT0:   r_shadow0 <= bus.din;
        SLOT1:   r_shadow1 <= bus.din;
        SLOT2:   r_shadow2 <= bus.din;
        default: r_shadow0 <= r_shadow0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out0       <= '0;
      r_out1       <= '0;
      r_out2       <= '0;
      r_out3       <= '0;
      r_frameValid <= 1'b0;
      r_syncError  <= 1'b0;
    end else begin
      r_frameValid <= w_commit;
      r_syncError  <= w_resync;
      if (w_commit) begin
        r_out0 <= r_shadow0;
        r_out1 <= r_shadow1;
        r_out2 <= r_shadow2;
        r_out3 <= bus.din;
      end
    end
  end

  assign bus.out0        = r_out0;
  assign bus.out1        = r_out1;
  assign bus.out2        = r_out2;
  assign bus.out3        = r_out3;
  assign bus.frame_valid = r_frameValid;
  assign bus.sync_error  = r_syncError;
  assign bus.slot_addr   = w_slot;
  assign bus.locked      = (r_state == LOCKED);

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Self-checking bench for tdm_demultiplexer: a behavioural model of the link predicts each
// cycle and queues every complete frame, which is popped when the design raises frame_valid.
module tb_tdm_demultiplexer;
  import tdm_pkg::*;

  localparam int W = 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  tdm_demultiplexer_if #(.WIDTH(W)) bus ();

  tdm_demultiplexer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checkCount  = 0;
  int failCount   = 0;
  int cycleCount  = 0;
  int lastFvCycle = -1;
  int lastFvGap   = 0;

  logic [4*W-1:0] expQ[$];
  logic [4*W-1:0] shownFrame;
  logic           mLocked;
  logic [1:0]     mSlot;
  logic [W-1:0]   mSh0, mSh1, mSh2;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mLocked    = 1'b0;
    mSlot      = 2'd0;
    mSh0       = '0;
    mSh1       = '0;
    mSh2       = '0;
    shownFrame = '0;
    expQ.delete();
  endtask

  // Drive one cycle, advance the model, then check the design one time unit after the edge.
  task automatic applyStimulus(input logic en, input logic sy, input logic [W-1:0] d);
    logic           expFv;
    logic           expErr;
    logic [4*W-1:0] frame;
    bus.enable = en;
    bus.sync   = sy;
    bus.din    = d;
    expFv  = 1'b0;
    expErr = 1'b0;
    if (en) begin
      if (!mLocked) begin
        if (sy) begin
          mLocked = 1'b1;
          mSh0    = d;
          mSlot   = 2'd1;
        end
      end else if (sy && mSlot != 2'd0) begin
        expErr = 1'b1;
        mSh0   = d;
        mSh1   = '0;
        mSh2   = '0;
        mSlot  = 2'd1;
      end else begin
        case (mSlot)
          2'd0: mSh0 = d;
          2'd1: mSh1 = d;
          2'd2: mSh2 = d;
          default: begin
            expQ.push_back({d, mSh2, mSh1, mSh0});
            expFv = 1'b1;
          end
        endcase
        mSlot = mSlot + 2'd1;
      end
    end
    @(posedge clk);
    #1;
    cycleCount++;
    checkOutput("frame_valid", 32'(bus.frame_valid), 32'(expFv));
    checkOutput("sync_error", 32'(bus.sync_error), 32'(expErr));
    checkOutput("locked", 32'(bus.locked), 32'(mLocked));
    checkOutput("slot_addr", 32'(bus.slot_addr), 32'(mSlot));
    if (bus.frame_valid && expQ.size() > 0) begin
      frame      = expQ.pop_front();
      shownFrame = frame;
      checkOutput("frame_data", 32'({bus.out3, bus.out2, bus.out1, bus.out0}), 32'(frame));
      if (lastFvCycle >= 0) lastFvGap = cycleCount - lastFvCycle;
      lastFvCycle = cycleCount;
    end else begin
      checkOutput("outputs_hold", 32'({bus.out3, bus.out2, bus.out1, bus.out0}),
                  32'(shownFrame));
    end
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.sync   = 1'b0;
    bus.din    = '0;
    reset      = 1'b1;
    modelReset();
    #2;
    checkOutput("reset_outputs", 32'({bus.out3, bus.out2, bus.out1, bus.out0}), 32'(0));
    checkOutput("reset_locked", 32'(bus.locked), 32'(0));
    checkOutput("reset_slot", 32'(bus.slot_addr), 32'(0));
    checkOutput("reset_valid", 32'(bus.frame_valid), 32'(0));
    #10;
    reset = 1'b0;

    $display("[TB] test 1: hunting without sync");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, W'(i & 1));

    $display("[TB] test 2: basic frame");
    applyStimulus(1'b1, 1'b1, W'(1));
    applyStimulus(1'b1, 1'b0, W'(0));
    applyStimulus(1'b1, 1'b0, W'(0));
    applyStimulus(1'b1, 1'b0, W'(0));
    applyStimulus(1'b0, 1'b0, W'(1));

    $display("[TB] test 3: back-to-back frames");
    applyStimulus(1'b1, 1'b1, W'(0));
    applyStimulus(1'b1, 1'b0, W'(1));
    applyStimulus(1'b1, 1'b0, W'(1));
    applyStimulus(1'b1, 1'b0, W'(1));
    applyStimulus(1'b1, 1'b0, W'(1));
    applyStimulus(1'b1, 1'b0, W'(0));
    applyStimulus(1'b1, 1'b0, W'(1));
    applyStimulus(1'b1, 1'b0, W'(1));
    checkOutput("frame_gap", 32'(lastFvGap), 32'(4));

    $display("[TB] test 4: misaligned sync");
    applyStimulus(1'b1, 1'b0, W'(1));
    applyStimulus(1'b1, 1'b0, W'(0));
    applyStimulus(1'b1, 1'b1, W'(0));
    applyStimulus(1'b1, 1'b0, W'(1));
    applyStimulus(1'b1, 1'b0, W'(1));
    applyStimulus(1'b1, 1'b0, W'(0));
    applyStimulus(1'b0, 1'b0, W'(0));

    $display("[TB] test 5: enable gaps");
    applyStimulus(1'b1, 1'b1, W'(1));
    applyStimulus(1'b1, 1'b0, W'(0));
    applyStimulus(1'b0, 1'b1, W'(1));
    applyStimulus(1'b0, 1'b0, W'(0));
    applyStimulus(1'b0, 1'b1, W'(1));
    applyStimulus(1'b1, 1'b0, W'(1));
    applyStimulus(1'b1, 1'b0, W'(1));

    $display("[TB] test 6: asynchronous reset mid-frame");
    applyStimulus(1'b1, 1'b1, W'(1));
    applyStimulus(1'b1, 1'b0, W'(1));
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("async_outputs", 32'({bus.out3, bus.out2, bus.out1, bus.out0}), 32'(0));
    checkOutput("async_locked", 32'(bus.locked), 32'(0));
    checkOutput("async_slot", 32'(bus.slot_addr), 32'(0));
    #3;
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, W'(1));
    applyStimulus(1'b1, 1'b1, W'(0));
    applyStimulus(1'b1, 1'b0, W'(1));
    applyStimulus(1'b1, 1'b0, W'(0));
    applyStimulus(1'b1, 1'b0, W'(1));
    applyStimulus(1'b0, 1'b0, W'(0));

    checkOutput("queue_empty", 32'(expQ.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
